// File: rtl/mb20_bank_ctl.sv
`default_nettype none
// ============================================================================
// Module      : mb20_bank_ctl
// Description : MBUS core-memory bank controller. Serves quadword read and
//               write cycles for one bank. Read data returns through a fixed
//               latency pipe with odd parity. Write data is parity-checked
//               before it is committed to storage.
// Revision    : 1.0 - initial release
// ============================================================================
module mb20_bank_ctl #(
  parameter int DATA_W     = 36,
  parameter int ADDR_W     = 22,
  parameter int DEPTH      = 262144,  // power of two, at least 8 words
  parameter int ACCESS_LAT = 2        // 1..8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] adr,
  input  logic [3:0]        rq,
  input  logic              wr,
  output logic              ackn,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_par,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_par,
  output logic              par_err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RSLOT = 3'd1,
    WACK  = 3'd2,
    WDATA = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t            state, state_nx;
  logic [1:0]        slot, slot_nx;
  logic [IDX_W-1:0]  adr_q;
  logic [3:0]        rq_q;

  logic              accept;
  logic              push_v;
  logic              wr_en;
  logic              perr_nx;
  logic              wpar_ok;
  logic              pipe_any;
  logic              ent_v;
  logic [IDX_W-1:0]  ent_a;
  logic [1:0]        word_off;
  logic [IDX_W-1:0]  word_idx;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              par_err_q;

  // Offset wraps inside the quadword; only storage-index bits are kept.
  assign word_off = adr_q[1:0] + slot;
  assign word_idx = {adr_q[IDX_W-1:2], word_off};
  assign wpar_ok  = ((~^wr_data) == wr_par);

  generate
    if (IDX_W < ADDR_W) begin : g_adr_hi
      // Address bits above the storage index do not select anything here.
      logic unused_adr_hi;
      assign unused_adr_hi = ^adr[ADDR_W-1:IDX_W];
    end
  endgenerate

  // Latency pipe: all stages except the output register live here.
  generate
    if (ACCESS_LAT == 1) begin : g_lat1
      assign ent_v    = push_v;
      assign ent_a    = word_idx;
      assign pipe_any = 1'b0;
    end else begin : g_latn
      logic [ACCESS_LAT-2:0] pv;
      logic [IDX_W-1:0]      pa [ACCESS_LAT-1];

      // Shift slot entries toward the output register every cycle.
      always_ff @(posedge clk) begin
        if (reset) begin
          pv <= '0;
        end else begin
          pv[0] <= push_v;
          pa[0] <= word_idx;
          for (int k = 1; k < ACCESS_LAT - 1; k++) begin
            pv[k] <= pv[k-1];
            pa[k] <= pa[k-1];
          end
        end
      end

      assign ent_v    = pv[ACCESS_LAT-2];
      assign ent_a    = pa[ACCESS_LAT-2];
      assign pipe_any = |pv;
    end
  endgenerate

  // State, slot counter and latched request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      slot  <= 2'd0;
      adr_q <= '0;
      rq_q  <= 4'd0;
    end else begin
      state <= state_nx;
      slot  <= slot_nx;
      if (accept) begin
        adr_q <= adr[IDX_W-1:0];
        rq_q  <= rq;
      end
    end
  end

  // Next-state, acknowledge, pipe push and write-commit decode.
  always_comb begin
    state_nx = state;
    slot_nx  = slot;
    ackn     = 1'b0;
    push_v   = 1'b0;
    wr_en    = 1'b0;
    perr_nx  = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (start && (rq != 4'd0)) begin
          accept   = 1'b1;
          slot_nx  = 2'd0;
          state_nx = wr ? WACK : RSLOT;
        end
      end
      RSLOT: begin
        ackn   = rq_q[slot];
        push_v = rq_q[slot];
        if (slot == 2'd3) begin
          state_nx = (push_v || pipe_any) ? DRAIN : IDLE;
        end else begin
          slot_nx = slot + 2'd1;
        end
      end
      DRAIN: begin
        // The output register empties on the edge that leaves DRAIN.
        if (!pipe_any) begin
          state_nx = IDLE;
        end
      end
      WACK: begin
        if (rq_q[slot]) begin
          ackn     = 1'b1;
          state_nx = WDATA;
        end else if (slot == 2'd3) begin
          state_nx = IDLE;
        end else begin
          slot_nx = slot + 2'd1;
        end
      end
      WDATA: begin
        if (wr_valid) begin
          if (wpar_ok) begin
            wr_en = ~reset;
          end else begin
            perr_nx = 1'b1;
          end
          if (slot == 2'd3) begin
            state_nx = IDLE;
          end else begin
            slot_nx  = slot + 2'd1;
            state_nx = WACK;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Storage is never cleared; a write in flight at reset is dropped.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[word_idx] <= wr_data;
    end
  end

  // Output register: read data is zero whenever it is not valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= ent_v;
      rd_data_q  <= ent_v ? mem[ent_a] : '0;
    end
  end

  // Write-parity error pulse, one cycle after the offending data edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= perr_nx;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_par   = rd_valid_q & (~^rd_data_q);
  assign par_err  = par_err_q;
  assign busy     = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mb20_bank_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mb20_bank_ctl
// Description : Directed self-checking bench for mb20_bank_ctl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mb20_bank_ctl;

  localparam int DW    = 36;
  localparam int AW    = 22;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] adr;
  logic [3:0]    rq;
  logic          wr;
  logic          ackn;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_par;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_par;
  logic          par_err;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mb20_bank_ctl #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .DEPTH     (DEPTH),
    .ACCESS_LAT(LAT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .adr     (adr),
    .rq      (rq),
    .wr      (wr),
    .ackn    (ackn),
    .rd_valid(rd_valid),
    .rd_data (rd_data),
    .rd_par  (rd_par),
    .wr_valid(wr_valid),
    .wr_data (wr_data),
    .wr_par  (wr_par),
    .par_err (par_err),
    .busy    (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Read cycle; e0..e3 are the words expected for slots 0..3.
  task automatic do_read(input logic [AW-1:0] a, input logic [3:0] m,
                         input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                         input logic [DW-1:0] e2, input logic [DW-1:0] e3);
    logic [DW-1:0] e [4];
    logic [DW-1:0] de;
    logic          av;
    logic          rv;
    int            busy_end;
    int            j;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    busy_end = 4;
    for (int i = 0; i < 4; i++)
      if (m[i] && (1 + i + LAT) > busy_end) busy_end = 1 + i + LAT;
    adr = a; rq = m; wr = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= LAT + 6; k++) begin
      @(negedge clk);
      av = 1'b0;
      if (k <= 4) av = m[k-1];
      j  = k - 1 - LAT;
      rv = 1'b0;
      de = '0;
      if (j >= 0 && j <= 3) begin
        rv = m[j];
        if (rv) de = e[j];
      end
      check($sformatf("rd_ackn k=%0d", k), 64'(ackn), 64'(av));
      check($sformatf("rd_valid k=%0d", k), 64'(rd_valid), 64'(rv));
      check($sformatf("rd_data k=%0d", k), 64'(rd_data), 64'(de));
      check($sformatf("rd_par k=%0d", k), 64'(rd_par), 64'(rv & (~^de)));
      check($sformatf("rd_busy k=%0d", k), 64'(busy), 64'(k <= busy_end));
    end
  endtask

  // Write cycle; bad[i] inverts the parity sent with slot i.
  task automatic do_write(input logic [AW-1:0] a, input logic [3:0] m,
                          input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                          input logic [DW-1:0] d2, input logic [DW-1:0] d3,
                          input logic [3:0] bad);
    logic [DW-1:0] d [4];
    int            n;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    adr = a; rq = m; wr = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("wr_busy", 64'(busy), 64'(1));
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        n = 0;
        while (!ackn && n < 20) begin
          @(negedge clk);
          n++;
        end
        check($sformatf("wr_ackn slot=%0d", i), 64'(ackn), 64'(1));
        @(negedge clk);
        check($sformatf("wr_ackn_drop slot=%0d", i), 64'(ackn), 64'(0));
        @(negedge clk);
        @(negedge clk);
        wr_data  = d[i];
        wr_par   = (~^d[i]) ^ bad[i];
        wr_valid = 1'b1;
        @(posedge clk);
        #1 wr_valid = 1'b0;
        @(negedge clk);
        check($sformatf("wr_par_err slot=%0d", i), 64'(par_err), 64'(bad[i]));
      end
    end
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wr_done_busy", 64'(busy), 64'(0));
    check("wr_done_perr", 64'(par_err), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; wr = 1'b0; adr = '0; rq = 4'd0;
    wr_valid = 1'b0; wr_data = '0; wr_par = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ackn", 64'(ackn), 64'(0));
    check("rst_rd_valid", 64'(rd_valid), 64'(0));
    check("rst_rd_data", 64'(rd_data), 64'(0));
    check("rst_rd_par", 64'(rd_par), 64'(0));
    check("rst_par_err", 64'(par_err), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'(0));

    // Preload 0x100..0x103 = 1,2,3,4.
    do_write(22'h100, 4'b1111, 36'd1, 36'd2, 36'd3, 36'd4, 4'b0000);
    // Offset 2 wraps: slots read 0x102,0x103,0x100,0x101.
    do_read(22'h102, 4'b1111, 36'd3, 36'd4, 36'd1, 36'd2);
    // Slots 0 and 2 only.
    do_read(22'h100, 4'b0101, 36'd1, 36'd0, 36'd3, 36'd0);
    // Good write of slots 1,2, then read back.
    do_write(22'h200, 4'b0110, 36'd0, 36'o123, 36'o456, 36'd0, 4'b0000);
    do_read(22'h200, 4'b0110, 36'd0, 36'o123, 36'o456, 36'd0);
    // Second word with bad parity must not commit.
    do_write(22'h200, 4'b0110, 36'd0, 36'o777, 36'o111, 36'd0, 4'b0100);
    do_read(22'h200, 4'b0110, 36'd0, 36'o777, 36'o456, 36'd0);

    // start with an empty mask is ignored.
    adr = 22'h100; rq = 4'd0; wr = 1'b0; start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rq0_busy", 64'(busy), 64'(0));
      check("rq0_ackn", 64'(ackn), 64'(0));
    end
    start = 1'b0;

    // Held start is only taken at the first edge with busy low.
    adr = 22'h100; rq = 4'b1111; wr = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("held_busy k=%0d", k), 64'(busy), 64'((k <= 6) || (k == 8)));
      if (k == 7) check("held_ackn_idle", 64'(ackn), 64'(0));
      if (k == 8) begin
        check("held_ackn_retake", 64'(ackn), 64'(1));
        start = 1'b0;
      end
    end
    n = 0;
    while (busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("held_done_busy", 64'(busy), 64'(0));

    // Reset in the middle of a read.
    adr = 22'h100; rq = 4'b1111; wr = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_ackn", 64'(ackn), 64'(0));
    check("mid_rst_rd_valid", 64'(rd_valid), 64'(0));
    check("mid_rst_rd_data", 64'(rd_data), 64'(0));
    check("mid_rst_rd_par", 64'(rd_par), 64'(0));
    check("mid_rst_par_err", 64'(par_err), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    repeat (6) begin
      @(negedge clk);
      check("mid_rst_quiet_valid", 64'(rd_valid), 64'(0));
      check("mid_rst_quiet_ackn", 64'(ackn), 64'(0));
    end
    do_read(22'h102, 4'b1111, 36'd3, 36'd4, 36'd1, 36'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
